wb_store_buffer: RTL and testbench

WB_STORE_BUFFER -- requirements
Module: wb_store_buffer

---
 rtl/wb_pkg.sv | 19 +
 rtl/sb_addr_match.sv | 23 ++
 rtl/wb_store_buffer.sv | 112 +++++++++++
 tb/tb_wb_store_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back store buffer: default sizes and the
// stored-entry layout.
package wb_pkg;

   localparam int WB_SB_DEPTH = 4;
   localparam int WB_ADDR_W   = 32;
   localparam int WB_DATA_W   = 32;
   localparam int WB_BE_W     = 4;

   // Loads are treated as touching the whole word when checking for overlap.
   localparam logic [WB_BE_W-1:0] WB_LD_BE_MASK = 4'hF;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic [WB_BE_W-1:0]   be;
   } sb_entry_t;

endpackage

// File: rtl/sb_addr_match.sv
// One store-vs-load overlap comparator: same word and at least one enabled
// byte inside the load mask.
module sb_addr_match
   import wb_pkg::*;
#(
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                 valid_i,
   input  logic [ADDR_W-1:0]    entry_addr_i,
   input  logic [WB_BE_W-1:0]   entry_be_i,
   input  logic [ADDR_W-1:0]    ld_addr_i,
   output logic                 hit_o
);

   logic unused_lsbs;

   assign unused_lsbs = ^{entry_addr_i[1:0], ld_addr_i[1:0]};

   assign hit_o = valid_i
                & (entry_addr_i[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])
                & (|(entry_be_i & WB_LD_BE_MASK));

endmodule

// File: rtl/wb_store_buffer.sv
// Circular FIFO of retired stores draining to the dcache in order, with a
// combinational load-overlap check against held and incoming stores.
module wb_store_buffer
   import wb_pkg::*;
#(
   parameter int SB_DEPTH = WB_SB_DEPTH,
   parameter int ADDR_W   = WB_ADDR_W
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic                 v_ex_dcache_write,
   input  logic [ADDR_W-1:0]    WB_MEM_ADDR,
   input  logic [WB_DATA_W-1:0] WB_MEM_DATA,
   input  logic [WB_BE_W-1:0]   WB_MEM_BE,
   input  logic                 EX_LD_V,
   input  logic [ADDR_W-1:0]    EX_LD_ADDR,
   input  logic                 DC_WR_ACK,
   output logic                 SB_DC_WR_V,
   output logic [ADDR_W-1:0]    SB_DC_ADDR,
   output logic [WB_DATA_W-1:0] SB_DC_DATA,
   output logic [WB_BE_W-1:0]   SB_DC_BE,
   output logic                 sb_stall_wb,
   output logic                 sb_ld_conflict,
   output logic                 sb_empty_all
);

   localparam int               PTR_W    = $clog2(SB_DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(SB_DEPTH);

   sb_entry_t          mem_q [SB_DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;

   logic               full;
   logic               push;
   logic               pop;
   logic [SB_DEPTH-1:0] occupied;
   logic [SB_DEPTH:0]   hit;

   assign full = (count_q == FULL_CNT);
   assign push = v_ex_dcache_write & ~full;
   assign pop  = SB_DC_WR_V & DC_WR_ACK;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry contents need no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge CLK) begin
      if (push && !CLR) begin
         mem_q[tail_q] <= '{addr: WB_MEM_ADDR, data: WB_MEM_DATA, be: WB_MEM_BE};
      end
   end

   always_comb begin
      logic [PTR_W-1:0] offset;
      occupied = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         offset      = PTR_W'(i) - head_q;
         occupied[i] = ({1'b0, offset} < count_q);
      end
   end

   for (genvar g = 0; g < SB_DEPTH; g++) begin : g_entry_match
      sb_addr_match #(.ADDR_W(ADDR_W)) u_match (
         .valid_i      (occupied[g]),
         .entry_addr_i (mem_q[g].addr),
         .entry_be_i   (mem_q[g].be),
         .ld_addr_i    (EX_LD_ADDR),
         .hit_o        (hit[g])
      );
   end

   sb_addr_match #(.ADDR_W(ADDR_W)) u_incoming_match (
      .valid_i      (v_ex_dcache_write),
      .entry_addr_i (WB_MEM_ADDR),
      .entry_be_i   (WB_MEM_BE),
      .ld_addr_i    (EX_LD_ADDR),
      .hit_o        (hit[SB_DEPTH])
   );

   assign SB_DC_WR_V     = (count_q != '0);
   assign SB_DC_ADDR     = mem_q[head_q].addr;
   assign SB_DC_DATA     = mem_q[head_q].data;
   assign SB_DC_BE       = mem_q[head_q].be;
   assign sb_stall_wb    = full & v_ex_dcache_write;
   assign sb_ld_conflict = EX_LD_V & (|hit);
   assign sb_empty_all   = (count_q == '0);

endmodule

// File: tb/tb_wb_store_buffer.sv
// Randomised and directed bench for wb_store_buffer, checked against a
// queue-based model of the buffer contents and a drain-order scoreboard.
module tb_wb_store_buffer;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        v_ex_dcache_write;
   logic [31:0] WB_MEM_ADDR;
   logic [31:0] WB_MEM_DATA;
   logic [3:0]  WB_MEM_BE;
   logic        EX_LD_V;
   logic [31:0] EX_LD_ADDR;
   logic        DC_WR_ACK;
   logic        SB_DC_WR_V;
   logic [31:0] SB_DC_ADDR;
   logic [31:0] SB_DC_DATA;
   logic [3:0]  SB_DC_BE;
   logic        sb_stall_wb;
   logic        sb_ld_conflict;
   logic        sb_empty_all;

   int checks = 0;
   int errors = 0;

   sb_entry_t model_q[$];
   sb_entry_t exp_q[$];

   wb_store_buffer #(.SB_DEPTH(DEPTH), .ADDR_W(32)) dut (
      .CLK               (CLK),
      .CLR               (CLR),
      .v_ex_dcache_write (v_ex_dcache_write),
      .WB_MEM_ADDR       (WB_MEM_ADDR),
      .WB_MEM_DATA       (WB_MEM_DATA),
      .WB_MEM_BE         (WB_MEM_BE),
      .EX_LD_V           (EX_LD_V),
      .EX_LD_ADDR        (EX_LD_ADDR),
      .DC_WR_ACK         (DC_WR_ACK),
      .SB_DC_WR_V        (SB_DC_WR_V),
      .SB_DC_ADDR        (SB_DC_ADDR),
      .SB_DC_DATA        (SB_DC_DATA),
      .SB_DC_BE          (SB_DC_BE),
      .sb_stall_wb       (sb_stall_wb),
      .sb_ld_conflict    (sb_ld_conflict),
      .sb_empty_all      (sb_empty_all)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic overlaps(input logic [31:0] st_addr, input logic [3:0] st_be,
                                     input logic [31:0] ld_addr);
      return (st_addr[31:2] == ld_addr[31:2]) && (st_be != 4'h0);
   endfunction

   function automatic logic model_conflict();
      logic c = 1'b0;
      if (!EX_LD_V) return 1'b0;
      foreach (model_q[i]) c |= overlaps(model_q[i].addr, model_q[i].be, EX_LD_ADDR);
      if (v_ex_dcache_write) c |= overlaps(WB_MEM_ADDR, WB_MEM_BE, EX_LD_ADDR);
      return c;
   endfunction

   // reference model: contents evolve at each rising edge from the applied inputs
   always @(posedge CLK) begin
      bit was_full;
      if (CLR) begin
         model_q.delete();
         exp_q.delete();
      end else begin
         was_full = (model_q.size() == DEPTH);
         if (model_q.size() != 0 && DC_WR_ACK) void'(model_q.pop_front());
         if (v_ex_dcache_write && !was_full) begin
            model_q.push_back('{addr: WB_MEM_ADDR, data: WB_MEM_DATA, be: WB_MEM_BE});
            exp_q.push_back('{addr: WB_MEM_ADDR, data: WB_MEM_DATA, be: WB_MEM_BE});
         end
      end
   end

   // monitor: status flags every cycle, drain order on each accepted write
   always @(negedge CLK) begin
      sb_entry_t e;
      chk("wr_v", 64'(SB_DC_WR_V), 64'(model_q.size() != 0));
      chk("empty_all", 64'(sb_empty_all), 64'(model_q.size() == 0));
      chk("stall_wb", 64'(sb_stall_wb), 64'((model_q.size() == DEPTH) && v_ex_dcache_write));
      chk("ld_conflict", 64'(sb_ld_conflict), 64'(model_conflict()));
      if (SB_DC_WR_V && DC_WR_ACK) begin
         if (exp_q.size() == 0) begin
            chk("drain_unexpected", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("drain_addr", 64'(SB_DC_ADDR), 64'(e.addr));
            chk("drain_data", 64'(SB_DC_DATA), 64'(e.data));
            chk("drain_be",   64'(SB_DC_BE),   64'(e.be));
         end
      end else if (model_q.size() != 0) begin
         chk("head_addr", 64'(SB_DC_ADDR), 64'(model_q[0].addr));
         chk("head_data", 64'(SB_DC_DATA), 64'(model_q[0].data));
         chk("head_be",   64'(SB_DC_BE),   64'(model_q[0].be));
      end
   end

   // driver: apply one cycle of inputs, hold them across the next rising edge
   task automatic drive(input logic clr, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic ldv,
                        input logic [31:0] la, input logic ack);
      CLR = clr; v_ex_dcache_write = v; WB_MEM_ADDR = a; WB_MEM_DATA = d;
      WB_MEM_BE = be; EX_LD_V = ldv; EX_LD_ADDR = la; DC_WR_ACK = ack;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input logic ack, input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, ack);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 32'h1000, 0);

      // single store, presented next cycle, then acked
      drive(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      idle(0, 1);
      idle(1, 1);
      idle(0, 2);

      // fill, overflow attempt, retry after one ack
      for (int i = 0; i < 4; i++)
         drive(0, 1, 32'h100 + 32'(i*4), 32'hA0 + 32'(i), 4'hF, 0, 0, 0);
      drive(0, 1, 32'h110, 32'hA4, 4'hF, 0, 0, 0);
      drive(0, 1, 32'h110, 32'hA4, 4'hF, 0, 0, 1);
      drive(0, 1, 32'h110, 32'hA4, 4'hF, 0, 0, 0);
      idle(1, 6);

      // streaming with ack every cycle, wrapping the pointers
      for (int i = 0; i < 10; i++)
         drive(0, 1, 32'h2000 + 32'(i*4), 32'h5000 + 32'(i), 4'hF, 0, 0, 1);
      idle(1, 3);

      // load overlap cases
      drive(0, 1, 32'h3004, 32'h11, 4'h1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 32'h3006, 0);
      drive(0, 0, 0, 0, 0, 1, 32'h3008, 0);
      drive(0, 1, 32'h3008, 32'h22, 4'hF, 1, 32'h3008, 0);
      drive(0, 0, 0, 0, 0, 1, 32'h300A, 0);
      idle(1, 3);

      // reset mid-drain
      drive(0, 1, 32'h5000, 32'h1, 4'hF, 0, 0, 0);
      drive(0, 1, 32'h5004, 32'h2, 4'hF, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1, 32'h5004, 0);
      drive(0, 0, 0, 0, 0, 1, 32'h5000, 1);

      // random traffic over a narrow address window to provoke overlaps
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 1)),
               32'h4000 + 32'($urandom_range(0, 31)),
               $urandom,
               4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)),
               32'h4000 + 32'($urandom_range(0, 31)),
               ($urandom_range(0, 2) != 0));
      end
      idle(1, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
